// File: rtl/pc_fetch.sv
// Program counter and instruction-fetch stage: tags every BRAM read, delivers {instr, pc} pairs to decode.
// Optional macro FETCH_ALIGN_CHECK_EN enables the sticky misaligned-redirect flag on fetch_misalign.
module pc_fetch #(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter int                READ_LAT  = 2,
    parameter logic [DATA_W-1:0] NOP_INSTR = DATA_W'(32'h0000_0013)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pc_choose,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic [ADDR_W-3:0] imem_addr,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic [DATA_W-1:0] instr_out,
    output logic [ADDR_W-1:0] pc_out,
    output logic              instr_valid,
    output logic [2:0]        inflight,
    output logic              fetch_misalign
);

    logic [ADDR_W-1:0]   pc;
    logic [ADDR_W-1:0]   pc_next;
    logic [READ_LAT-1:0] tag_v;
    logic [READ_LAT-1:0] tag_v_next;
    logic [ADDR_W-1:0]   tag_pc [READ_LAT];
    logic [2:0]          inflight_next;
    logic                issue;
    logic                deliver;

    // A redirect outranks both a new issue and the read completing this cycle.
    assign issue     = pc_choose && !branch_taken;
    assign deliver   = tag_v[READ_LAT-1] && !branch_taken;
    assign imem_addr = pc[ADDR_W-1:2];

    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path can infer a latch.
        pc_next       = pc;
        tag_v_next    = (tag_v << 1) | READ_LAT'(issue);
        inflight_next = '0;
        if (branch_taken) begin
            pc_next    = {branch_target[ADDR_W-1:2], 2'b00};
            tag_v_next = '0;
        end else if (pc_choose) begin
            pc_next = pc + ADDR_W'(4);
        end
        for (int k = 0; k < READ_LAT; k++) begin
            inflight_next = inflight_next + 3'(tag_v_next[k]);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            pc          <= RESET_PC;
            tag_v       <= '0;
            inflight    <= '0;
            instr_out   <= NOP_INSTR;
            pc_out      <= RESET_PC;
            instr_valid <= 1'b0;
        end else begin
            pc          <= pc_next;
            tag_v       <= tag_v_next;
            inflight    <= inflight_next;
            instr_valid <= deliver;
            if (deliver) begin
                instr_out <= imem_rdata;
                pc_out    <= tag_pc[READ_LAT-1];
            end
        end
    end

    // NOTE: tag PCs are left unreset; tag_v alone decides whether an entry means anything.
    always_ff @(posedge clk) begin
        tag_pc[0] <= pc;
        for (int k = 1; k < READ_LAT; k++) begin
            tag_pc[k] <= tag_pc[k-1];
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    logic misalign_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            misalign_q <= 1'b0;
        end else if (branch_taken && (branch_target[1:0] != 2'b00)) begin
            misalign_q <= 1'b1;
        end
    end

    assign fetch_misalign = misalign_q;
`else
    logic unused_target_bits;

    assign unused_target_bits = ^branch_target[1:0];
    assign fetch_misalign     = 1'b0;
`endif

endmodule

// File: doc/pc_fetch.md
Name: pc_fetch

Overview:
Program-counter and instruction-fetch stage feeding decode.
- Holds the PC and drives the word address to the instruction BRAM, which has a fixed read latency.
- Tracks each outstanding read with a tagged latency pipe and presents instruction/PC pairs to decode with a valid strobe.
- Advance is gated by the pc_choose strobe from the stall FSM; branch redirects squash all in-flight fetches.

Parameters:
ADDR_W, 32, byte-address width of PC
DATA_W, 32, instruction width
RESET_PC, 0, PC value loaded on reset (word aligned)
READ_LAT, 2, BRAM read latency in cycles (legal 1..4)
NOP_INSTR, 32'h00000013, value driven on instr_out after reset

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
pc_choose  in  1  1 = issue fetch at current PC and advance; 0 = hold PC
branch_taken  in  1  redirect request from execute
branch_target  in  ADDR_W  redirect byte address
imem_addr  out  ADDR_W-2  BRAM word address = pc[ADDR_W-1:2], combinational from PC register
imem_rdata  in  DATA_W  BRAM read data, valid READ_LAT cycles after the address is presented
instr_out  out  DATA_W  fetched instruction (registered)
pc_out  out  ADDR_W  PC of instr_out (registered)
instr_valid  out  1  one-cycle pulse per delivered instruction
inflight  out  3  number of valid tags in the latency pipe
fetch_misalign  out  1  sticky misaligned-redirect flag (see Optional Feature)

Behaviour:
- Reset (sync, active-high; takes priority over everything):
  - pc <= RESET_PC; all tags invalid; inflight <= 0.
  - instr_out <= NOP_INSTR; pc_out <= RESET_PC; instr_valid <= 0; fetch_misalign <= 0.
- State: pc register; tag pipe t[1..READ_LAT], each entry {v, pc}.
- Issue, cycle N (pc_choose=1, branch_taken=0):
  - imem_addr shows pc;
  - t[1] <= {1, pc};
  - pc <= pc + 4, modulo 2^ADDR_W (wraps to 0).
- Hold (pc_choose=0, branch_taken=0): pc unchanged; t[1] <= {0, x}. The pipe still shifts, so outstanding reads continue to complete.
- Redirect (branch_taken=1, any pc_choose):
  - pc <= {branch_target[ADDR_W-1:2], 2'b00}.
  - Every tag, including the one completing this cycle, is cleared; t[1] <= invalid.
  - No instr_valid pulse next cycle.
  - The first fetch from the target issues in the following cycle, if pc_choose=1.
- Shift: t[k+1] <= t[k] every cycle. A tag issued at cycle N reaches t[READ_LAT] in cycle N+READ_LAT, aligned with imem_rdata.
- Delivery: at the edge ending cycle N+READ_LAT, if t[READ_LAT].v and no redirect:
  - instr_out <= imem_rdata; pc_out <= t[READ_LAT].pc;
  - instr_valid <= 1 (high during cycle N+READ_LAT+1).
  - Issue-to-valid latency = READ_LAT+1 cycles.
- Otherwise: instr_valid <= 0; instr_out and pc_out hold their last values.
- Throughput: one instruction per cycle when pc_choose is held high. With a 0,1,1 strobe pattern, valid follows the same pattern delayed by READ_LAT+1.
- inflight = popcount of tag valid bits, registered alongside the pipe. It is never greater than READ_LAT.
- Reset during outstanding reads: all tags are dropped and no stale BRAM data is ever delivered.
- No backpressure from decode; downstream must consume each valid pulse.

Optional Feature:
Macro FETCH_ALIGN_CHECK_EN.
- Defined: a redirect with branch_target[1:0] != 0 sets fetch_misalign <= 1 at that edge. The flag is sticky until reset. The redirect still proceeds with the low bits cleared.
- Undefined: fetch_misalign is tied to 0 and low bits are cleared silently. The port exists in both builds.

Test Plan:
1. Reset, then pc_choose=1 continuously, BRAM model returning addr-tagged data → instr_valid first high 3 cycles after reset release; pc_out = 0, 4, 8, ... with no gaps; inflight settles at 2.
2. pc_choose pattern 0,1,1 repeating → valid pulses follow the same pattern delayed 3 cycles; pc_out increments by 4 per pulse only.
3. Steady fetch with branch_taken=1, target 0x100, in cycle 10 → both in-flight fetches squashed; no valid in cycles 11–12; next pc_out = 0x100 with valid in cycle 14 (issue in cycle 11, READ_LAT+1 = 3).
4. RESET_PC = 2^ADDR_W−4 → pc_out sequence 0xFFFFFFFC, 0x00000000, 0x00000004.
5. Assert reset with 2 fetches outstanding → next cycle instr_valid = 0, instr_out = 0x00000013, inflight = 0; no stale data delivered.
6. FETCH_ALIGN_CHECK_EN defined, redirect to 0x102 → fetch_misalign = 1 and stays high; next pc_out = 0x100. Undefined build → fetch_misalign stays 0.
